// File: rtl/nes_loader_pkg.sv
// Shared definitions for the cartridge load/dump path: SDRAM memory map,
// iNES header field positions and the dumper state encoding.
package nes_loader_pkg;

    // SDRAM byte addresses of each cartridge region; the loader writes here
    // and the dumper reads back from the same places.
    localparam logic [24:0] PRG_BASE_ADDR   = 25'h0000000;
    localparam logic [24:0] CHR_BASE_ADDR   = 25'h0200000;
    localparam logic [24:0] EXTRA_BASE_ADDR = 25'h0400000;

    // iNES header layout.
    localparam int HDR_BYTES         = 16;
    localparam int HDR_PRG_PAGES_IDX = 4;
    localparam int HDR_CHR_PAGES_IDX = 5;

    // Largest value the accepted-byte counter may hold before it saturates.
    localparam logic [22:0] BYTES_SENT_MAX = 23'h7FFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } dump_state_t;

    typedef enum logic {
        SEG_PRG,
        SEG_CHR
    } dump_seg_t;

endpackage

// File: rtl/nes_image_dumper.sv
// Streams a loaded cartridge back out of SDRAM in iNES order: the 16 header
// bytes, then PRG-ROM, then CHR-ROM. One byte-read per output byte, with a
// registered valid/ready output stage.
module nes_image_dumper
    import nes_loader_pkg::*;
#(
    parameter logic [24:0] PRG_BASE = PRG_BASE_ADDR,
    parameter logic [24:0] CHR_BASE = CHR_BASE_ADDR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] header,
    input  logic [21:0]  prg_bytes,
    input  logic [21:0]  chr_bytes,
    output logic [24:0]  mem_addr,
    output logic         mem_rd,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_ack,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [22:0]  bytes_sent
);

    dump_state_t  r_state;
    dump_seg_t    r_seg;
    logic [127:0] r_header;
    logic [21:0]  r_prg_len;
    logic [21:0]  r_chr_len;
    logic [21:0]  r_bytes_left;
    logic [3:0]   r_ctr;

    logic         w_handshake;
    logic [3:0]   w_next_ctr;

    assign w_handshake = out_valid && out_ready;
    assign w_next_ctr  = r_ctr + 4'd1;

    // Dump sequencer: walks header -> PRG -> CHR, issuing one read per byte and
    // holding each byte in the output register until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_seg        <= SEG_PRG;
            r_header     <= '0;
            r_prg_len    <= '0;
            r_chr_len    <= '0;
            r_bytes_left <= '0;
            r_ctr        <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bytes_sent   <= '0;
        end else begin
            mem_rd <= 1'b0;

            if (w_handshake && bytes_sent != BYTES_SENT_MAX) begin
                bytes_sent <= bytes_sent + 23'd1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_header   <= header;
                        r_prg_len  <= prg_bytes;
                        r_chr_len  <= chr_bytes;
                        r_ctr      <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        bytes_sent <= '0;
                        out_data   <= header[7:0];
                        out_valid  <= 1'b1;
                        r_state    <= S_HEADER;
                    end
                end

                S_HEADER: begin
                    if (out_ready) begin
                        if (r_ctr == 4'(HDR_BYTES - 1)) begin
                            out_valid <= 1'b0;
                            if (r_prg_len != '0) begin
                                r_seg        <= SEG_PRG;
                                mem_addr     <= PRG_BASE;
                                r_bytes_left <= r_prg_len;
                                mem_rd       <= 1'b1;
                                r_state      <= S_REQ;
                            end else if (r_chr_len != '0) begin
                                r_seg        <= SEG_CHR;
                                mem_addr     <= CHR_BASE;
                                r_bytes_left <= r_chr_len;
                                mem_rd       <= 1'b1;
                                r_state      <= S_REQ;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_ctr    <= w_next_ctr;
                            out_data <= r_header[{w_next_ctr, 3'b000} +: 8];
                        end
                    end
                end

                S_REQ: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_ack) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        r_state   <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mem_addr  <= mem_addr + 25'd1;
                        if (r_bytes_left != '0) begin
                            r_bytes_left <= r_bytes_left - 22'd1;
                        end
                        if (r_bytes_left <= 22'd1) begin
                            if (r_seg == SEG_PRG && r_chr_len != '0) begin
                                r_seg        <= SEG_CHR;
                                mem_addr     <= CHR_BASE;
                                r_bytes_left <= r_chr_len;
                                mem_rd       <= 1'b1;
                                r_state      <= S_REQ;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            mem_rd  <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nes_image_dumper.md
# nes_image_dumper

Reads a loaded cartridge back out of SDRAM and serialises it as a byte stream in iNES order: 16-byte header, then PRG-ROM, then CHR-ROM. It is the inverse of the download-side loader and sits between the SDRAM arbiter's byte-read port and the host bridge's upload FIFO. It is used for ROM export and for load-path verification.

## Interface
Parameters:
- PRG_BASE, 25'h0000000, SDRAM byte address of PRG-ROM.
- CHR_BASE, 25'h0200000, SDRAM byte address of CHR-ROM.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a dump; ignored while busy.
- header  in  128  the 16 header bytes; byte n is on [8n+7:8n].
- prg_bytes  in  22  PRG length in bytes; 0 means skip the PRG segment.
- chr_bytes  in  22  CHR length in bytes; 0 means skip (CHR-RAM cart).
- mem_addr  out  25  read address.
- mem_rd  out  1  read request, one cycle per byte.
- mem_rdata  in  8  read data.
- mem_ack  in  1  mem_rdata valid; arrives 1 or more cycles after mem_rd.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts on out_valid && out_ready.
- busy  out  1  dump in progress.
- done  out  1  dump completed; sticky until the next accepted start.
- bytes_sent  out  23  count of accepted stream bytes.

## Operation
- States: S_IDLE, S_HEADER, S_REQ, S_WAIT, S_EMIT, S_DONE. A segment flag (PRG or CHR) selects the base address and length.
- On reset, all outputs are 0 and the state is S_IDLE.
- start in S_IDLE, S_DONE or after reset:
  - Latches header, prg_bytes and chr_bytes.
  - Clears done and bytes_sent, sets busy, clears the byte counter.
  - Goes to S_HEADER.
- S_HEADER:
  - Presents header byte ctr (4-bit counter) with out_valid=1.
  - Each handshake increments ctr.
  - On the handshake of byte 15, the next segment is selected: PRG if prg_bytes is nonzero, else CHR if chr_bytes is nonzero, else S_DONE.
  - Entering a segment sets mem_addr to that segment's base and bytes_left to its length, then goes to S_REQ.
- S_REQ: asserts mem_rd for exactly 1 cycle, then goes to S_WAIT.
- S_WAIT:
  - On mem_ack, captures mem_rdata into the out_data register and goes to S_EMIT.
  - mem_ack in any other state is ignored.
- S_EMIT:
  - Holds out_valid=1 with stable out_data until the handshake.
  - On the handshake, mem_addr increments and bytes_left decrements.
  - If bytes_left was 1, the segment ends: PRG→CHR (or S_DONE if chr_bytes is 0); CHR→S_DONE.
  - Otherwise goes to S_REQ.
- S_DONE: done=1, busy=0, out_valid=0. Stays here until start.
- bytes_sent increments on every handshake and saturates at 23'h7FFFFF. It never wraps.
- Arithmetic widths: mem_addr adds are 25-bit. bytes_left is 22-bit and is never decremented below 0.
- reset mid-dump: returns immediately to S_IDLE with out_valid, mem_rd, busy and done all 0. Any in-flight mem_ack is dropped.
- start while busy: ignored; no state change.
- out_ready held high while out_valid=0: no effect.

## Timing
- start at cycle T: busy=1 and out_valid=1 with header byte 0 at T+1.
- With out_ready=1, header bytes stream one per cycle (T+1..T+16).
- Per ROM byte with ack latency L: 1 cycle in S_REQ, L cycles in S_WAIT, 1+ cycles in S_EMIT. With out_ready=1, throughput is 1 byte per L+2 cycles.
- mem_addr is stable from the mem_rd cycle through the mem_ack cycle.
- out_data/out_valid are registered, with no combinational path from out_ready. Per the handshake rule, out_data must not change while out_valid=1 && !out_ready.
- done rises in the cycle after the final handshake; busy falls in the same cycle.

## Structure
- Shared package nes_loader_pkg holds:
  - PRG/CHR/extra base address localparams, shared with the loader so both ends agree on the memory map.
  - The dumper state enum.
  - The header-byte index constants (4=PRG pages, 5=CHR pages).
- No sub-module is required; the design is a single FSM with a registered output stage.

## Test plan
- header="NES\x1A",0x01,0x00…; prg_bytes=16384; chr_bytes=0; memory = address low byte -> 16400 bytes: header, then 0x00..0xFF repeating. Final mem_addr is 0x0003FFF, then done=1 and bytes_sent=16400.
- prg_bytes=16384, chr_bytes=8192 -> the first CHR mem_rd has mem_addr=0x0200000; the stream total is 24592 bytes in PRG-then-CHR order.
- Random out_ready (50%) with ack latency of 1..5 random cycles -> stream identical to the no-stall run; out_data never changes while stalled; exactly one mem_rd per byte.
- prg_bytes=0, chr_bytes=0 -> exactly 16 header bytes, no mem_rd, done at the cycle after the 16th handshake.
- reset asserted during PRG byte 100 with mem_ack pending -> next cycle all outputs are 0; the late ack is ignored; a new start restarts at header byte 0.
- start pulsed again mid-dump -> no effect; done is still reached with the original byte count.
